// File: rtl/button_intr_pkg.sv
// Shared constants for the button interrupt AXI4-Lite slave:
// register offsets, response code and FSM state types.
package button_intr_pkg;

   localparam logic [4:0] ADDR_GIE = 5'h00;
   localparam logic [4:0] ADDR_IER = 5'h04;
   localparam logic [4:0] ADDR_ISR = 5'h08;
   localparam logic [4:0] ADDR_IAR = 5'h0C;
   localparam logic [4:0] ADDR_IPR = 5'h10;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

endpackage

// File: rtl/button_debounce.sv
// One button input: 2-flop synchronizer, stability counter,
// debounced level and a registered rising-edge pulse.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rise_q, rise_d;

   // Counter restarts whenever the input agrees with the stable level
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      rise_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/button_intr_axil_slave.sv
// AXI4-Lite slave exposing GIE/IER/ISR/IAR/IPR for debounced
// push-button interrupts, with a registered irq output.
module button_intr_axil_slave
   import button_intr_pkg::*;
#(
   parameter int unsigned NUM_INTR           = 4,
   parameter int unsigned DEBOUNCE_CYCLES    = 16,
   parameter int unsigned IRQ_ACTIVE_HIGH    = 1,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [NUM_INTR-1:0]           btn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic                          irq
);

   wr_state_e w_state_q, w_state_d;
   rd_state_e r_state_q, r_state_d;

   logic                gie_q, gie_d;
   logic [NUM_INTR-1:0] ier_q, ier_d;
   logic [NUM_INTR-1:0] isr_q, isr_d;
   logic [NUM_INTR-1:0] clr, rise, wmask;
   logic                irq_q, irq_d;
   logic [31:0]         rdata_q, rdata_d, rmux;
   logic                wr_acc, rd_acc;
   logic [2:0]          wsel, rsel;
   logic                unused_ok;

   for (genvar i = 0; i < NUM_INTR; i++) begin : g_db
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i (S_AXI_ACLK),
         .rst_ni(S_AXI_ARESETN),
         .btn_i (btn[i]),
         .rise_o(rise[i])
      );
   end

   assign wsel   = S_AXI_AWADDR[4:2];
   assign rsel   = S_AXI_ARADDR[4:2];
   assign wr_acc = (w_state_q == W_IDLE) & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_acc = (r_state_q == R_IDLE) & S_AXI_ARVALID;

   always_comb begin
      w_state_d = w_state_q;
      unique case (w_state_q)
         W_IDLE:  if (wr_acc) w_state_d = W_RESP;
         W_RESP:  if (S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      unique case (r_state_q)
         R_IDLE:  if (rd_acc) r_state_d = R_DATA;
         R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      gie_d = gie_q;
      ier_d = ier_q;
      clr   = '0;
      for (int b = 0; b < NUM_INTR; b++) begin
         wmask[b] = S_AXI_WSTRB[b / 8];
      end
      if (wr_acc) begin
         case (wsel)
            ADDR_GIE[4:2]: if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
            ADDR_IER[4:2]: ier_d = (ier_q & ~wmask)
                                 | (S_AXI_WDATA[NUM_INTR-1:0] & wmask);
            ADDR_IAR[4:2]: clr = S_AXI_WDATA[NUM_INTR-1:0] & wmask;
            default: ;
         endcase
      end
      // A fresh edge overrides a same-cycle acknowledge so it is not lost
      isr_d = (isr_q & ~clr) | rise;
      irq_d = gie_q & |(isr_q & ier_q);
   end

   always_comb begin
      rmux = '0;
      case (rsel)
         ADDR_GIE[4:2]: rmux[0] = gie_q;
         ADDR_IER[4:2]: rmux[NUM_INTR-1:0] = ier_q;
         ADDR_ISR[4:2]: rmux[NUM_INTR-1:0] = isr_q;
         ADDR_IPR[4:2]: rmux[NUM_INTR-1:0] = isr_q & ier_q;
         default: ;
      endcase
      rdata_d = rd_acc ? rmux : rdata_q;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         gie_q     <= 1'b0;
         ier_q     <= '0;
         isr_q     <= '0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         gie_q     <= gie_d;
         ier_q     <= ier_d;
         isr_q     <= isr_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_AXI_AWREADY = wr_acc;
   assign S_AXI_WREADY  = wr_acc;
   assign S_AXI_ARREADY = rd_acc;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign S_AXI_RDATA   = rdata_q;
   assign irq           = (IRQ_ACTIVE_HIGH != 0) ? irq_q : ~irq_q;

   assign unused_ok = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA, S_AXI_WSTRB};

endmodule

// File: tb/tb_button_intr_axil_slave.sv
// Randomized bench for button_intr_axil_slave with a windowed
// debounce reference model and per-cycle irq checking.
module tb_button_intr_axil_slave;

   localparam int D    = 16;
   localparam int HMAX = 40000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  btn;
   logic [4:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   button_intr_axil_slave #(
      .NUM_INTR(4), .DEBOUNCE_CYCLES(D),
      .IRQ_ACTIVE_HIGH(1), .C_S_AXI_ADDR_WIDTH(5)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .btn(btn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata),
      .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
      .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata),
      .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [3:0]  hist [HMAX];
   int          cyc = 0;
   logic        gie_m, irq_m;
   logic [3:0]  ier_m, isr_m, rise_m, stab_m;
   bit          wr_go = 0, rd_go = 0, chk_irq = 0;
   logic [4:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_exp;
   logic [3:0]  wr_strb;

   function automatic logic [31:0] reg_val(input logic [4:0] a);
      case (a[4:2])
         3'd0:    return {31'd0, gie_m};
         3'd1:    return {28'd0, ier_m};
         3'd2:    return {28'd0, isr_m};
         3'd4:    return {28'd0, isr_m & ier_m};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic hsamp(input int idx, input int b);
      if (idx < 0 || idx >= HMAX) return 1'b0;
      return hist[idx][b];
   endfunction

   // Debounced level flips once the last D synchronized samples
   // (btn seen two edges earlier) all disagree with it.
   always @(posedge clk) begin
      logic [3:0]  rise_n, clr, m;
      bit          all_diff;
      if (cyc < HMAX) hist[cyc] = rst_n ? btn : 4'd0;
      if (!rst_n) begin
         gie_m = 0; ier_m = 0; isr_m = 0; irq_m = 0;
         rise_m = 0; stab_m = 0; wr_go = 0; rd_go = 0;
      end else begin
         irq_m = gie_m & |(isr_m & ier_m);
         if (rd_go) begin
            rd_exp = reg_val(rd_addr);
            rd_go = 0;
         end
         clr = 0;
         if (wr_go) begin
            for (int b = 0; b < 4; b++) m[b] = wr_strb[0];
            case (wr_addr[4:2])
               3'd0: if (wr_strb[0]) gie_m = wr_data[0];
               3'd1: ier_m = (ier_m & ~m) | (wr_data[3:0] & m);
               3'd3: clr = wr_data[3:0] & m;
               default: ;
            endcase
            wr_go = 0;
         end
         isr_m = (isr_m & ~clr) | rise_m;
         rise_n = 0;
         for (int b = 0; b < 4; b++) begin
            all_diff = 1;
            for (int k = 0; k < D; k++)
               if (hsamp(cyc - 2 - k, b) == stab_m[b]) all_diff = 0;
            if (all_diff) begin
               stab_m[b] = ~stab_m[b];
               if (stab_m[b]) rise_n[b] = 1'b1;
            end
         end
         rise_m = rise_n;
      end
      cyc++;
   end

   always @(negedge clk)
      if (rst_n && chk_irq) check("irq", {31'd0, irq}, {31'd0, irq_m});

   task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold);
      int n;
      @(negedge clk);
      awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
      bready = (hold == 0);
      #1;
      n = 0;
      while (!awready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!awready) begin
         check("aw_timeout", 0, 1);
         awvalid = 0; wvalid = 0;
         return;
      end
      check("wready", {31'd0, wready}, 1);
      wr_addr = a; wr_data = d; wr_strb = s; wr_go = 1;
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      check("bvalid", {31'd0, bvalid}, 1);
      check("bresp", {30'd0, bresp}, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bvalid_hold", {31'd0, bvalid}, 1);
      end
      bready = 1;
      @(negedge clk);
      check("bvalid_clr", {31'd0, bvalid}, 0);
   endtask

   task automatic axi_rd(input logic [4:0] a, input int hold,
                         output logic [31:0] d);
      int n;
      d = 'x;
      @(negedge clk);
      araddr = a; arvalid = 1; rready = (hold == 0);
      #1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (!arready) begin
         check("ar_timeout", 0, 1);
         arvalid = 0;
         return;
      end
      rd_addr = a; rd_go = 1;
      @(negedge clk);
      arvalid = 0;
      check("rvalid", {31'd0, rvalid}, 1);
      check($sformatf("rdata_%h", a), rdata, rd_exp);
      check("rresp", {30'd0, rresp}, 0);
      d = rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rvalid_hold", {31'd0, rvalid}, 1);
         check("rdata_hold", rdata, d);
      end
      rready = 1;
      @(negedge clk);
      check("rvalid_clr", {31'd0, rvalid}, 0);
   endtask

   initial begin
      logic [31:0] d;
      logic [4:0]  a;
      int          p, cnt, idx;
      rst_n = 0; btn = 0;
      awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 1; araddr = 0; arvalid = 0; rready = 1;
      repeat (3) @(negedge clk);
      check("rst_awready", {31'd0, awready}, 0);
      check("rst_wready", {31'd0, wready}, 0);
      check("rst_arready", {31'd0, arready}, 0);
      check("rst_bvalid", {31'd0, bvalid}, 0);
      check("rst_rvalid", {31'd0, rvalid}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_irq", {31'd0, irq}, 0);
      rst_n = 1;
      chk_irq = 1;

      for (int i = 0; i <= 5; i++) begin
         a = 5'(i * 4);
         axi_rd(a, 0, d);
         check("reset_reg", d, 0);
      end

      // Basic press, acknowledge
      axi_wr(5'h00, 32'h1, 4'hF, 0);
      axi_wr(5'h04, 32'h1, 4'hF, 0);
      btn[0] = 1;
      repeat (22) @(negedge clk);
      axi_rd(5'h08, 0, d); check("isr_btn0", d, 32'h1);
      axi_rd(5'h10, 0, d); check("ipr_btn0", d, 32'h1);
      axi_wr(5'h0C, 32'h1, 4'hF, 0);
      axi_rd(5'h10, 0, d); check("ipr_ack", d, 32'h0);
      btn[0] = 0;
      repeat (22) @(negedge clk);

      // Short glitch is rejected
      btn[1] = 1;
      repeat (10) @(negedge clk);
      btn[1] = 0;
      repeat (25) @(negedge clk);
      axi_rd(5'h08, 0, d); check("isr_glitch", d, 32'h0);

      // Pending while disabled, exposed by IER
      axi_wr(5'h04, 32'h0, 4'hF, 0);
      btn[2] = 1;
      repeat (25) @(negedge clk);
      axi_rd(5'h08, 0, d); check("isr_masked", d, 32'h4);
      axi_rd(5'h10, 0, d); check("ipr_masked", d, 32'h0);
      axi_wr(5'h04, 32'h4, 4'hF, 0);
      repeat (3) @(negedge clk);
      axi_rd(5'h10, 0, d); check("ipr_enabled", d, 32'h4);
      axi_wr(5'h0C, 32'h4, 4'hF, 0);
      btn[2] = 0;
      repeat (25) @(negedge clk);

      // New edge lands on the IAR accept edge
      axi_wr(5'h04, 32'h1, 4'hF, 0);
      btn[0] = 1;
      repeat (25) @(negedge clk);
      btn[0] = 0;
      repeat (25) @(negedge clk);
      btn[0] = 1;
      p = cyc;
      while (cyc != p + D + 1) @(negedge clk);
      axi_wr(5'h0C, 32'h1, 4'hF, 0);
      axi_rd(5'h08, 0, d); check("isr_set_wins", d & 32'h1, 32'h1);
      btn[0] = 0;
      repeat (25) @(negedge clk);
      axi_wr(5'h0C, 32'hF, 4'hF, 0);

      // Backpressure and lone AW
      axi_wr(5'h04, 32'h5, 4'hF, 5);
      axi_rd(5'h04, 5, d); check("ier_hold", d, 32'h5);
      @(negedge clk);
      awaddr = 5'h04; awvalid = 1; wvalid = 0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (awready) cnt++;
         @(negedge clk);
      end
      awvalid = 0;
      check("aw_only", cnt, 0);

      // Randomized mix
      for (int it = 0; it < 250; it++) begin
         a = 5'($urandom_range(0, 7) << 2);
         case ($urandom_range(0, 4))
            0, 1: begin
               idx = $urandom_range(0, 3);
               btn[idx] = ~btn[idx];
               repeat ($urandom_range(1, 30)) @(negedge clk);
            end
            2: axi_wr(a, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2));
            default: axi_rd(a, $urandom_range(0, 2), d);
         endcase
      end

      // Reset in the middle of open responses
      btn = 0;
      repeat (25) @(negedge clk);
      chk_irq = 0;
      awaddr = 5'h00; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1; wvalid = 1; bready = 0;
      araddr = 5'h08; arvalid = 1; rready = 0;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("mid_bvalid", {31'd0, bvalid}, 1);
      check("mid_rvalid", {31'd0, rvalid}, 1);
      rst_n = 0;
      #1;
      check("rst_drop_bvalid", {31'd0, bvalid}, 0);
      check("rst_drop_rvalid", {31'd0, rvalid}, 0);
      check("rst_drop_irq", {31'd0, irq}, 0);
      repeat (2) @(negedge clk);
      bready = 1; rready = 1;
      rst_n = 1;
      chk_irq = 1;
      axi_rd(5'h00, 0, d); check("gie_after_rst", d, 32'h0);
      axi_rd(5'h08, 0, d); check("isr_after_rst", d, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
